alu_operand_path: RTL and testbench
===================================

ALU_OPERAND_PATH -- requirements
Module: alu_operand_path

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; all values below assume 32.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port en, input, 1, load enable for the registered outputs.
REQ-005 SHALL have port op, input, 4, ALU operation code.
REQ-006 SHALL have port a_sel, input, 1, A-operand select.
REQ-007 SHALL have port b_sel, input, 2, B-operand select.
REQ-008 SHALL have port reg_a, input, 32, register-file A data.
REQ-009 SHALL have port reg_b, input, 32, register-file B data.
REQ-010 SHALL have port pc, input, 30, word program counter.
REQ-011 SHALL have port imm16, input, 16, instruction immediate.
REQ-012 SHALL have port imm24, input, 24, branch displacement.
REQ-013 SHALL have port res, output, 32, combinational ALU result.
REQ-014 SHALL have port res_q, output, 32, registered ALU result.
REQ-015 SHALL have port cr_q, output, 1, registered condition bit.

Function
REQ-016 A operand SHALL be reg_a when a_sel=0 and {2'b00,pc} when a_sel=1.
REQ-017 B operand SHALL be selected by b_sel:
- 00: reg_b.
- 01: {16'h0,imm16}, zero-extended.
- 10: imm24 sign-extended from bit 23.
- 11: 32'h0.
REQ-018 res SHALL be combinational in op, A and B, with no clock latency.
REQ-019 Operations 0-4, per op:
- 0 ADD: A+B mod 2^32.
- 1 SUB: A-B mod 2^32.
- 2 AND.
- 3 OR.
- 4 XOR.
REQ-020 Operations 5-7 (shift amount B[4:0]):
- 5 LSL.
- 6 LSR.
- 7 ASR.
REQ-021 Operations 8-11:
- 8 MOVB: B.
- 9 NOTB: ~B.
- 10 MOVA: A.
- 11 reserved: 32'h0.
REQ-022 Operations 12-15 (compare class, op[3:2]=11) SHALL produce 32'h1 if true, else 32'h0:
- 12 SLT: signed A<B.
- 13 SLTU: unsigned A<B.
- 14 SEQ: A==B.
- 15 SC: carry-out of A+B.
REQ-023 When rst=0 and en=1, on each rising clk: res_q SHALL load res (latency 1 cycle).
REQ-024 When rst=0 and en=1, cr_q SHALL load res[0] only when op[3:2]=11; otherwise cr_q holds.
REQ-025 When en=0, res_q and cr_q SHALL hold their values.
REQ-026 Arithmetic SHALL wrap silently, with no overflow flag; SUB of equal operands SHALL give 0.

Reset
REQ-027 rst=1 at a rising clk SHALL set res_q=32'h0 and cr_q=0, with priority over en.
REQ-028 Reset SHALL NOT affect res, which stays combinational.
REQ-029 Deasserting rst SHALL allow loading from the next clk edge with en=1.

Configuration
REQ-030 Macro ALU_SHIFT_EN, when defined, SHALL compile in the ops 5/6/7 shift logic.
REQ-031 When ALU_SHIFT_EN is undefined, ops 5/6/7 SHALL return 32'h0 and no shifter SHALL be synthesized; all other ops are unchanged.

Verification
REQ-032 rst=1 for one edge with en=1 and op=0, A=5, B=3 -> res_q=0, cr_q=0; next edge with rst=0 -> res_q=8.
REQ-033 a_sel=1, pc=30'h10, b_sel=10, imm24=24'hFFFFFE, op=0 -> res=32'h0000000E.
REQ-034 b_sel=01, imm16=16'h8000, reg_a=0, op=3 -> res=32'h00008000 (no sign extension).
REQ-035 op=12, reg_a=32'hFFFFFFFF, reg_b=1 -> res=1, and cr_q=1 after an en=1 edge; op=13 with the same operands -> res=0.
REQ-036 op=15, A=32'hFFFFFFFF, B=1 -> res=1; op=1, A=0, B=1 -> res=32'hFFFFFFFF; en=0 edge -> res_q unchanged.
REQ-037 ALU_SHIFT_EN defined: op=7, A=32'h80000000, B=4 -> 32'hF8000000; undefined: -> 32'h0.

Source files
------------

// File: rtl/alu_operand_path.sv
// ALU operand selection, combinational ALU and registered result/condition bit.
// Define ALU_SHIFT_EN to build the LSL/LSR/ASR shifter; otherwise ops 5-7 give zero.
module alu_operand_path #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       op,
  input  logic             a_sel,
  input  logic [1:0]       b_sel,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [29:0]      pc,
  input  logic [15:0]      imm16,
  input  logic [23:0]      imm24,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_q,
  output logic             cr_q
);

  logic        [WIDTH-1:0] a_op;
  logic        [WIDTH-1:0] b_op;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [WIDTH:0]   sum_c;
  logic        [WIDTH-1:0] diff;
  logic                    flag;

  always_comb begin
    a_op = a_sel ? {{(WIDTH-30){1'b0}}, pc} : reg_a;
    unique case (b_sel)
      2'b00:   b_op = reg_b;
      2'b01:   b_op = {{(WIDTH-16){1'b0}}, imm16};
      2'b10:   b_op = {{(WIDTH-24){imm24[23]}}, imm24};
      default: b_op = '0;
    endcase
  end

  assign a_s   = a_op;
  assign b_s   = b_op;
  // One adder serves both ADD and the carry-out compare.
  assign sum_c = {1'b0, a_op} + {1'b0, b_op};
  assign diff  = a_op - b_op;

`ifdef ALU_SHIFT_EN
  logic [4:0] shamt;
  assign shamt = b_op[4:0];
`endif

  always_comb begin
    flag = 1'b0;
    unique case (op[1:0])
      2'b00:   flag = (a_s < b_s);
      2'b01:   flag = (a_op < b_op);
      2'b10:   flag = (a_op == b_op);
      default: flag = sum_c[WIDTH];
    endcase
  end

  always_comb begin
    res = '0;
    unique case (op)
      4'd0:  res = sum_c[WIDTH-1:0];
      4'd1:  res = diff;
      4'd2:  res = a_op & b_op;
      4'd3:  res = a_op | b_op;
      4'd4:  res = a_op ^ b_op;
`ifdef ALU_SHIFT_EN
      4'd5:  res = a_op << shamt;
      4'd6:  res = a_op >> shamt;
      4'd7:  res = a_s >>> shamt;
`else
      4'd5:  res = '0;
      4'd6:  res = '0;
      4'd7:  res = '0;
`endif
      4'd8:  res = b_op;
      4'd9:  res = ~b_op;
      4'd10: res = a_op;
      4'd11: res = '0;
      default: res = {{(WIDTH-1){1'b0}}, flag};
    endcase
  end

  // Stage boundary: registered result and condition bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      cr_q  <= 1'b0;
    end else if (en) begin
      res_q <= res;
      if (op[3:2] == 2'b11) cr_q <= res[0];
    end
  end

endmodule

// File: tb/tb_alu_operand_path.sv
// Bench for alu_operand_path: directed vectors, literal expectations and a cycle model.
module tb_alu_operand_path;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  op = 4'd0;
  logic        a_sel = 1'b0;
  logic [1:0]  b_sel = 2'b00;
  logic [31:0] reg_a = 32'h0;
  logic [31:0] reg_b = 32'h0;
  logic [29:0] pc = 30'h0;
  logic [15:0] imm16 = 16'h0;
  logic [23:0] imm24 = 24'h0;
  logic [31:0] res;
  logic [31:0] res_q;
  logic        cr_q;

  int n_cmp = 0;
  int n_fail = 0;
  bit done = 1'b0;

  logic [31:0] m_res_q;
  logic        m_cr_q;
  bit          m_known = 1'b0;

  alu_operand_path #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .a_sel(a_sel), .b_sel(b_sel),
    .reg_a(reg_a), .reg_b(reg_b), .pc(pc), .imm16(imm16), .imm24(imm24),
    .res(res), .res_q(res_q), .cr_q(cr_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] opnd_a();
    return a_sel ? {2'b00, pc} : reg_a;
  endfunction

  function automatic logic [31:0] opnd_b();
    case (b_sel)
      2'b00:   return reg_b;
      2'b01:   return {16'h0, imm16};
      2'b10:   return imm24[23] ? {8'hFF, imm24} : {8'h00, imm24};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint two32 = 64'sh1_0000_0000;
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    longint sa = a[31] ? ua - two32 : ua;
    longint sb = b[31] ? ub - two32 : ub;
    int     sh = int'(b[4:0]);
    longint r = 0;
    case (o)
      4'd0:  r = ua + ub;
      4'd1:  r = ua - ub + two32;
      4'd2:  r = longint'({32'h0, a & b});
      4'd3:  r = longint'({32'h0, a | b});
      4'd4:  r = longint'({32'h0, a ^ b});
`ifdef ALU_SHIFT_EN
      4'd5:  r = ua << sh;
      4'd6:  r = ua >> sh;
      4'd7:  r = sa >>> sh;
`endif
      4'd8:  r = ub;
      4'd9:  r = longint'({32'h0, ~b});
      4'd10: r = ua;
      4'd12: r = (sa < sb) ? 1 : 0;
      4'd13: r = (ua < ub) ? 1 : 0;
      4'd14: r = (ua == ub) ? 1 : 0;
      4'd15: r = (ua + ub >= two32) ? 1 : 0;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
    a_sel = 1'b0;
    b_sel = 2'b00;
    reg_a = a;
    reg_b = b;
  endtask

  // Reference registers advance on the same edge as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_res_q <= 32'h0;
      m_cr_q  <= 1'b0;
      m_known <= 1'b1;
    end else if (en) begin
      m_res_q <= model(op, opnd_a(), opnd_b());
      if (op >= 4'd12) m_cr_q <= model(op, opnd_a(), opnd_b()) & 32'h1;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      check("model_res", res, model(op, opnd_a(), opnd_b()));
      if (m_known) begin
        check("model_res_q", res_q, m_res_q);
        check("model_cr_q", {31'h0, cr_q}, {31'h0, m_cr_q});
      end
    end
  end

  typedef struct { logic [3:0] o; logic [31:0] e; } vec_t;
  vec_t vt[16];

  initial begin
    vt[0]  = '{4'd0,  32'hF0F00F13};
    vt[1]  = '{4'd1,  32'hF0F00F0B};
    vt[2]  = '{4'd2,  32'h00000004};
    vt[3]  = '{4'd3,  32'hF0F00F0F};
    vt[4]  = '{4'd4,  32'hF0F00F0B};
`ifdef ALU_SHIFT_EN
    vt[5]  = '{4'd5,  32'h0F00F0F0};
    vt[6]  = '{4'd6,  32'h0F0F00F0};
    vt[7]  = '{4'd7,  32'hFF0F00F0};
`else
    vt[5]  = '{4'd5,  32'h0};
    vt[6]  = '{4'd6,  32'h0};
    vt[7]  = '{4'd7,  32'h0};
`endif
    vt[8]  = '{4'd8,  32'h00000004};
    vt[9]  = '{4'd9,  32'hFFFFFFFB};
    vt[10] = '{4'd10, 32'hF0F00F0F};
    vt[11] = '{4'd11, 32'h0};
    vt[12] = '{4'd12, 32'h1};
    vt[13] = '{4'd13, 32'h0};
    vt[14] = '{4'd14, 32'h0};
    vt[15] = '{4'd15, 32'h0};

    tick();
    tick();
    check("reset_res_q", res_q, 32'h0);
    check("reset_cr_q", {31'h0, cr_q}, 32'h0);

    // Reset has priority over en; loading resumes on the following edge.
    en = 1'b1; op = 4'd0; set_ab(32'd5, 32'd3);
    #1 check("add_comb_in_reset", res, 32'd8);
    tick();
    check("rst_prio_res_q", res_q, 32'h0);
    check("rst_prio_cr_q", {31'h0, cr_q}, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_res_q", res_q, 32'd8);

    a_sel = 1'b1; pc = 30'h10; b_sel = 2'b10; imm24 = 24'hFFFFFE; op = 4'd0;
    #1 check("pc_plus_simm24", res, 32'h0000000E);
    tick();
    a_sel = 1'b0; reg_a = 32'h0; b_sel = 2'b01; imm16 = 16'h8000; op = 4'd3;
    #1 check("imm16_zext", res, 32'h00008000);
    tick();

    op = 4'd12; set_ab(32'hFFFFFFFF, 32'd1);
    #1 check("slt_true", res, 32'h1);
    tick();
    check("slt_cr_q", {31'h0, cr_q}, 32'h1);
    op = 4'd13;
    #1 check("sltu_false", res, 32'h0);
    tick();
    check("sltu_cr_q", {31'h0, cr_q}, 32'h0);

    op = 4'd15;
    #1 check("sc_carry", res, 32'h1);
    tick();
    check("sc_cr_q", {31'h0, cr_q}, 32'h1);
    op = 4'd1; set_ab(32'h0, 32'd1);
    #1 check("sub_wrap", res, 32'hFFFFFFFF);
    tick();
    check("sub_res_q", res_q, 32'hFFFFFFFF);
    check("noncmp_cr_hold", {31'h0, cr_q}, 32'h1);
    en = 1'b0; op = 4'd0; set_ab(32'd5, 32'd3);
    tick();
    check("en0_hold_res_q", res_q, 32'hFFFFFFFF);
    check("en0_hold_cr_q", {31'h0, cr_q}, 32'h1);
    en = 1'b1;

    op = 4'd7; set_ab(32'h80000000, 32'd4);
`ifdef ALU_SHIFT_EN
    #1 check("asr_sign", res, 32'hF8000000);
`else
    #1 check("asr_disabled", res, 32'h0);
`endif
    tick();
    op = 4'd1; set_ab(32'h1234, 32'h1234);
    #1 check("sub_equal", res, 32'h0);
    tick();
    op = 4'd8; b_sel = 2'b11; reg_b = 32'hDEADBEEF;
    #1 check("bsel_zero", res, 32'h0);
    tick();
    op = 4'd10; a_sel = 1'b1; pc = 30'h3FFFFFFF;
    #1 check("mova_pc", res, 32'h3FFFFFFF);
    tick();

    for (int i = 0; i < 16; i++) begin
      op = vt[i].o; set_ab(32'hF0F00F0F, 32'h00000004);
      #1 check($sformatf("op%0d_table", i), res, vt[i].e);
      tick();
    end

    rst = 1'b1;
    tick();
    check("rst2_res_q", res_q, 32'h0);
    check("rst2_cr_q", {31'h0, cr_q}, 32'h0);
    rst = 1'b0;
    tick();

    done = 1'b1;
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
